life_ctrl: RTL

Command-driven sequencer for a 16x16 Game of Life cell array. Accepts clear, load-row, run-N-generations and dump commands over a valid/ready port. Drives the array's write, step, select and reset controls. Streams the board back out row by row. Sits between the host/UART front end and the array, owning every array control line.

---
 rtl/life_pkg.sv | 25 ++
 rtl/life_ctrl_gen_counter.sv | 37 +++
 rtl/life_ctrl.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/life_pkg.sv
// Shared definitions for the Game of Life array controller.
package life_pkg;

    localparam int unsigned ROWS_DEF  = 16;
    localparam int unsigned COLS_DEF  = 16;
    localparam int unsigned GEN_W_DEF = 16;

    typedef enum logic [1:0] {
        OP_CLEAR = 2'b00,
        OP_LOAD  = 2'b01,
        OP_RUN   = 2'b10,
        OP_DUMP  = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LOAD,
        S_STEP,
        S_GAP,
        S_DUMP_SEL,
        S_DUMP_OUT
    } state_t;

endpackage

// File: rtl/life_ctrl_gen_counter.sv
// Remaining-generation down-counter and saturating generation counter.
module life_ctrl_gen_counter
    import life_pkg::*;
#(
    parameter int unsigned GEN_W = GEN_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [GEN_W-1:0] load_value,
    input  logic             step_done,
    input  logic             clr,
    output logic [GEN_W-1:0] remaining,
    output logic [GEN_W-1:0] gen_count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            remaining <= '0;
            gen_count <= '0;
        end else begin
            if (load) begin
                remaining <= load_value;
            end else if (step_done && (remaining != '0)) begin
                remaining <= remaining - GEN_W'(1);
            end

            // gen_count sticks at all-ones until the next CLEAR
            if (clr) begin
                gen_count <= '0;
            end else if (step_done && (gen_count != '1)) begin
                gen_count <= gen_count + GEN_W'(1);
            end
        end
    end

endmodule

// File: rtl/life_ctrl.sv
// Command sequencer owning every control line of the Game of Life cell array.
module life_ctrl
    import life_pkg::*;
#(
    parameter int unsigned ROWS  = ROWS_DEF,
    parameter int unsigned COLS  = COLS_DEF,
    parameter int unsigned GEN_W = GEN_W_DEF,
    localparam int unsigned ROW_W = $clog2(ROWS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [ROW_W-1:0] cmd_row,
    input  logic [COLS-1:0]  cmd_data,
    input  logic [GEN_W-1:0] cmd_count,
    input  logic             cmd_abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ROW_W-1:0] out_row,
    output logic [COLS-1:0]  out_data,
    output logic             arr_reset,
    output logic             arr_write_enb,
    output logic [COLS-1:0]  arr_vali,
    output logic [ROW_W-1:0] arr_vali_selector,
    output logic             arr_step,
    output logic [ROW_W-1:0] arr_valo_selector,
    input  logic [COLS-1:0]  arr_valo,
    output logic             busy,
    output logic [GEN_W-1:0] gen_count
);

    state_t           state;
    logic             abort_q;
    logic [GEN_W-1:0] remaining;
    logic             cnt_load;
    logic             cnt_step_done;
    logic             cnt_clr;

    assign cnt_load      = (state == S_IDLE) && cmd_valid && (cmd_op == OP_RUN);
    assign cnt_step_done = (state == S_GAP);
    assign cnt_clr       = (state == S_CLEAR);

    life_ctrl_gen_counter #(
        .GEN_W(GEN_W)
    ) u_gen_counter (
        .clk        (clk),
        .reset      (reset),
        .load       (cnt_load),
        .load_value (cmd_count),
        .step_done  (cnt_step_done),
        .clr        (cnt_clr),
        .remaining  (remaining),
        .gen_count  (gen_count)
    );

    // Outputs are assigned alongside the next state so each strobe lands in the state it belongs to
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= S_IDLE;
            cmd_ready         <= 1'b1;
            busy              <= 1'b0;
            arr_reset         <= 1'b1;
            arr_write_enb     <= 1'b0;
            arr_step          <= 1'b0;
            arr_vali          <= '0;
            arr_vali_selector <= '0;
            arr_valo_selector <= '0;
            out_valid         <= 1'b0;
            out_row           <= '0;
            out_data          <= '0;
            abort_q           <= 1'b0;
        end else begin
            arr_reset     <= 1'b0;
            arr_write_enb <= 1'b0;
            arr_step      <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        abort_q <= 1'b0;
                        case (op_t'(cmd_op))
                            OP_CLEAR: begin
                                state     <= S_CLEAR;
                                arr_reset <= 1'b1;
                                cmd_ready <= 1'b0;
                                busy      <= 1'b1;
                            end
                            OP_LOAD: begin
                                state             <= S_LOAD;
                                arr_write_enb     <= 1'b1;
                                arr_vali          <= cmd_data;
                                arr_vali_selector <= cmd_row;
                                cmd_ready         <= 1'b0;
                                busy              <= 1'b1;
                            end
                            OP_RUN: begin
                                if (cmd_count != '0) begin
                                    state     <= S_STEP;
                                    arr_step  <= 1'b1;
                                    cmd_ready <= 1'b0;
                                    busy      <= 1'b1;
                                end
                            end
                            OP_DUMP: begin
                                state             <= S_DUMP_SEL;
                                arr_valo_selector <= '0;
                                cmd_ready         <= 1'b0;
                                busy              <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end

                S_CLEAR, S_LOAD: begin
                    state     <= S_IDLE;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                end

                S_STEP: begin
                    state <= S_GAP;
                    if (cmd_abort) begin
                        abort_q <= 1'b1;
                    end
                end

                // remaining still holds the pre-decrement value here
                S_GAP: begin
                    if ((remaining > GEN_W'(1)) && !abort_q && !cmd_abort) begin
                        state    <= S_STEP;
                        arr_step <= 1'b1;
                    end else begin
                        state     <= S_IDLE;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end

                S_DUMP_SEL: begin
                    out_data  <= arr_valo;
                    out_row   <= arr_valo_selector;
                    out_valid <= 1'b1;
                    state     <= S_DUMP_OUT;
                end

                S_DUMP_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (arr_valo_selector == ROW_W'(ROWS - 1)) begin
                            state     <= S_IDLE;
                            cmd_ready <= 1'b1;
                            busy      <= 1'b0;
                        end else begin
                            arr_valo_selector <= arr_valo_selector + ROW_W'(1);
                            state             <= S_DUMP_SEL;
                        end
                    end
                end

                default: begin
                    state     <= S_IDLE;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
